// File: rtl/aes0_axi_driver.sv
// aes0_axi_driver: AXI-lite master that programs the AES-192 peripheral for one command at a time and returns the ciphertext
module aes0_axi_driver #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int POLL_LIMIT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_1,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] cmd_pt_i,
  input  logic [127:0] cmd_state_i,
  input  logic [191:0] cmd_key_i,
  input  logic [1:0]   cmd_ksel_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [127:0] res_ct_o,
  output logic         res_err_o,
  output logic         busy_o,
  output logic         aw_valid_o,
  input  logic         aw_ready_i,
  output logic [63:0]  aw_addr_o,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [63:0]  w_data_o,
  output logic [7:0]   w_strb_o,
  input  logic         b_valid_i,
  output logic         b_ready_o,
  input  logic [1:0]   b_resp_i,
  output logic         ar_valid_o,
  input  logic         ar_ready_i,
  output logic [63:0]  ar_addr_o,
  input  logic         r_valid_i,
  output logic         r_ready_o,
  input  logic [63:0]  r_data_i,
  input  logic [1:0]   r_resp_i
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
  typedef enum logic [1:0] {CFG, POLL, RD, CLR} stage_t;
  state_t state, state_n;
  stage_t stage, stage_n;
  logic [4:0] cnt, cnt_n;
  logic [31:0] poll, poll_n;
  logic err, err_n, aw_done, aw_done_n, w_done, w_done_n;
  logic [1:0] ksel_q;
  logic [5:0][31:0] key_q;
  logic [3:0][31:0] st_q, pt_q, ct_q;
  logic [2:0] kk;
  logic [1:0] ks, kp;
  logic [5:0] bank, widx, ridx;
  logic [31:0] wword;
  logic unused_hi;
  assign unused_hi = ^r_data_i[63:32];
  assign cmd_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign aw_valid_o = state == WADDR && !aw_done;
  assign w_valid_o = state == WADDR && !w_done;
  assign aw_addr_o = aw_valid_o ? BASE_ADDR + 64'({widx, 3'b000}) : 64'h0;
  assign w_data_o = w_valid_o ? {32'h0, wword} : 64'h0;
  assign w_strb_o = w_valid_o ? 8'hFF : 8'h00;
  assign b_ready_o = state == WRESP;
  assign ar_valid_o = state == RADDR;
  assign ar_addr_o = ar_valid_o ? BASE_ADDR + 64'({ridx, 3'b000}) : 64'h0;
  assign r_ready_o = state == RDATA;
  assign res_valid_o = state == RESP;
  assign res_err_o = res_valid_o && err;
  assign res_ct_o = (res_valid_o && !err) ? ct_q : 128'h0;
  always_comb begin
    kk = 3'(cnt - 5'd1);
    ks = 2'(cnt - 5'd7);
    kp = 2'(cnt - 5'd11);
    bank = ksel_q == 2'd0 ? 6'd5 : ksel_q == 2'd1 ? 6'd20 : 6'd26;
    widx = (stage == CLR || cnt == 5'd15) ? 6'd0 : cnt == 5'd0 ? 6'd32 : cnt <= 5'd6 ? bank + 6'(kk) :
           cnt <= 5'd10 ? 6'd16 + 6'(ks) : 6'd1 + 6'(kp);
    wword = stage == CLR ? 32'h0 : cnt == 5'd0 ? {30'h0, ksel_q} : cnt <= 5'd6 ? key_q[kk] :
            cnt <= 5'd10 ? st_q[ks] : cnt <= 5'd14 ? pt_q[kp] : 32'h1;
    ridx = stage == POLL ? 6'd11 : 6'd12 + 6'(cnt[1:0]);
  end
  always_comb begin
    state_n = state;
    stage_n = stage;
    cnt_n = cnt;
    poll_n = poll;
    err_n = err;
    aw_done_n = aw_done;
    w_done_n = w_done;
    case (state)
      IDLE: if (cmd_valid_i) begin
        state_n = WADDR;
        stage_n = CFG;
        cnt_n = 5'd0;
        err_n = 1'b0;
      end
      WADDR: begin
        aw_done_n = aw_done || aw_ready_i;
        w_done_n = w_done || w_ready_i;
        if (aw_done_n && w_done_n) begin
          state_n = WRESP;
          aw_done_n = 1'b0;
          w_done_n = 1'b0;
        end
      end
      WRESP: if (b_valid_i) begin
        if (b_resp_i != 2'b00 || stage == CLR) begin
          err_n = err || b_resp_i != 2'b00;
          state_n = stage == CLR ? RESP : WADDR;
          stage_n = CLR;
        end else if (cnt == 5'd15) begin
          state_n = RADDR;
          stage_n = POLL;
          poll_n = 32'h0;
        end else begin
          state_n = WADDR;
          cnt_n = cnt + 5'd1;
        end
      end
      RADDR: if (ar_ready_i) state_n = RDATA;
      RDATA: if (r_valid_i) begin
        if (r_resp_i != 2'b00) begin
          err_n = 1'b1;
          stage_n = CLR;
          state_n = WADDR;
        end else if (stage == POLL) begin
          if (r_data_i[0]) begin
            stage_n = RD;
            cnt_n = 5'd0;
            state_n = RADDR;
          end else if (poll == 32'(POLL_LIMIT - 1)) begin
            err_n = 1'b1;
            stage_n = CLR;
            state_n = WADDR;
          end else begin
            poll_n = poll + 32'h1;
            state_n = RADDR;
          end
        end else if (cnt[1:0] == 2'd3) begin
          stage_n = CLR;
          state_n = WADDR;
        end else begin
          cnt_n = cnt + 5'd1;
          state_n = RADDR;
        end
      end
      RESP: if (res_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_1) begin
      state <= IDLE;
      stage <= CFG;
      cnt <= 5'd0;
      poll <= 32'h0;
      err <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      cnt <= cnt_n;
      poll <= poll_n;
      err <= err_n;
      aw_done <= aw_done_n;
      w_done <= w_done_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (cmd_valid_i && cmd_ready_o) begin
      ksel_q <= cmd_ksel_i;
      key_q <= cmd_key_i;
      st_q <= cmd_state_i;
      pt_q <= cmd_pt_i;
      ct_q <= 128'h0;
    end
    if (state == RDATA && r_valid_i && stage == RD) ct_q[cnt[1:0]] <= r_data_i[31:0];
  end
endmodule

// File: tb/tb_aes0_axi_driver.sv
// tb_aes0_axi_driver: scoreboard bench with a stallable AXI-lite slave model of the AES peripheral
module tb_aes0_axi_driver;
  logic clk_i = 1'b0;
  logic rst_1 = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o;
  logic [127:0] cmd_pt_i = '0, cmd_state_i = '0, res_ct_o;
  logic [191:0] cmd_key_i = '0;
  logic [1:0] cmd_ksel_i = '0;
  logic res_valid_o, res_ready_i = 1'b0, res_err_o, busy_o;
  logic aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, b_valid_i, b_ready_o;
  logic ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
  logic [63:0] aw_addr_o, w_data_o, ar_addr_o, r_data_i;
  logic [7:0] w_strb_o;
  logic [1:0] b_resp_i, r_resp_i;
  always #5 clk_i = ~clk_i;
  aes0_axi_driver #(.BASE_ADDR(64'h0), .POLL_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_1(rst_1),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_pt_i(cmd_pt_i), .cmd_state_i(cmd_state_i),
    .cmd_key_i(cmd_key_i), .cmd_ksel_i(cmd_ksel_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_ct_o(res_ct_o), .res_err_o(res_err_o), .busy_o(busy_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
  );
  typedef struct { bit wr; logic [63:0] addr; logic [31:0] data; } acc_t;
  acc_t exp_q[$], act_q[$];
  acc_t e, a;
  int errors = 0, checks = 0;
  int stall = 0, ct_poll = 3, berr_n = 0, wr_n = 0, poll_n = 0, viol = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  bit aw_got = 0, w_got = 0, r_pend = 0, aw_pend = 0, w_pend = 0, ar_pend = 0;
  bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [63:0] aw_a, w_d, ra, aw_pa, w_pd, ar_pa;
  logic [127:0] ct_val = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ST = 128'h0f0e0d0c0b0a09080706050403020100;
  function automatic logic [63:0] rd(input logic [63:0] addr);
    int idx;
    idx = int'(addr[8:3]);
    if (idx == 11) begin
      poll_n++;
      return (ct_poll != 0 && poll_n >= ct_poll) ? 64'h1 : 64'h0;
    end
    if (idx >= 12 && idx <= 15) return {32'h0, ct_val[32*(idx-12) +: 32]};
    return 64'h0;
  endfunction
  initial begin
    {aw_ready_i, w_ready_i, b_valid_i, ar_ready_i, r_valid_i} = '0;
    b_resp_i = 2'b00;
    r_resp_i = 2'b00;
    r_data_i = 64'h0;
    forever begin
      @(posedge clk_i);
      aw_fire = aw_valid_o && aw_ready_i;
      w_fire = w_valid_o && w_ready_i;
      b_fire = b_valid_i && b_ready_o;
      ar_fire = ar_valid_o && ar_ready_i;
      r_fire = r_valid_i && r_ready_o;
      if (rst_1) begin
        {aw_got, w_got, r_pend, aw_pend, w_pend, ar_pend} = '0;
      end else begin
        if (aw_valid_o && ar_valid_o) viol++;
        if (aw_pend && !(aw_valid_o && aw_addr_o == aw_pa)) viol++;
        if (w_pend && !(w_valid_o && w_data_o == w_pd)) viol++;
        if (ar_pend && !(ar_valid_o && ar_addr_o == ar_pa)) viol++;
        aw_pend = aw_valid_o && !aw_ready_i;
        aw_pa = aw_addr_o;
        w_pend = w_valid_o && !w_ready_i;
        w_pd = w_data_o;
        ar_pend = ar_valid_o && !ar_ready_i;
        ar_pa = ar_addr_o;
        if (aw_fire) begin aw_got = 1; aw_a = aw_addr_o; end
        if (w_fire) begin
          w_got = 1;
          w_d = w_data_o;
          if (w_strb_o !== 8'hFF || w_data_o[63:32] !== 32'h0) viol++;
        end
        if (b_fire) begin
          act_q.push_back('{1'b1, aw_a, w_d[31:0]});
          aw_got = 0;
          w_got = 0;
          wr_n++;
        end
        if (ar_fire) begin
          if (aw_got || w_got) viol++;
          r_pend = 1;
          ra = ar_addr_o;
          act_q.push_back('{1'b0, ar_addr_o, 32'h0});
        end
        if (r_fire) r_pend = 0;
      end
      #1;
      if (rst_1) begin
        {aw_ready_i, w_ready_i, b_valid_i, ar_ready_i, r_valid_i} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
      end else begin
        aw_ready_i = 0;
        if (aw_valid_o && !aw_got) begin
          if (aw_c == 0) begin aw_ready_i = 1; aw_c = $urandom_range(0, stall); end else aw_c--;
        end
        w_ready_i = 0;
        if (w_valid_o && !w_got) begin
          if (w_c == 0) begin w_ready_i = 1; w_c = $urandom_range(0, stall); end else w_c--;
        end
        ar_ready_i = 0;
        if (ar_valid_o && !r_pend) begin
          if (ar_c == 0) begin ar_ready_i = 1; ar_c = $urandom_range(0, stall); end else ar_c--;
        end
        if (b_fire) b_valid_i = 0;
        if (aw_got && w_got && !b_valid_i) begin
          if (b_c == 0) begin
            b_valid_i = 1;
            b_resp_i = (wr_n + 1 == berr_n) ? 2'b10 : 2'b00;
            b_c = $urandom_range(0, stall);
          end else b_c--;
        end
        if (r_fire) r_valid_i = 0;
        if (r_pend && !r_valid_i) begin
          if (r_c == 0) begin
            r_valid_i = 1;
            r_data_i = rd(ra);
            r_resp_i = 2'b00;
            r_c = $urandom_range(0, stall);
          end else r_c--;
        end
      end
    end
  end
  task automatic push_exp(input logic [1:0] ks, input logic [191:0] key, input logic [127:0] st, pt,
                          output logic [127:0] ect, output logic eer);
    logic [63:0] wa [16];
    logic [31:0] wd [16];
    int bank, np;
    bank = ks == 2'd0 ? 5 : ks == 2'd1 ? 20 : 26;
    wa[0] = 64'(32 * 8);
    wd[0] = {30'h0, ks};
    for (int k = 0; k < 6; k++) begin wa[1+k] = 64'((bank + k) * 8); wd[1+k] = key[32*k +: 32]; end
    for (int k = 0; k < 4; k++) begin wa[7+k] = 64'((16 + k) * 8); wd[7+k] = st[32*k +: 32]; end
    for (int k = 0; k < 4; k++) begin wa[11+k] = 64'((1 + k) * 8); wd[11+k] = pt[32*k +: 32]; end
    wa[15] = 64'h0;
    wd[15] = 32'h1;
    ect = 128'h0;
    eer = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{1'b1, wa[i], wd[i]});
      if (berr_n == i + 1) begin exp_q.push_back('{1'b1, 64'h0, 32'h0}); return; end
    end
    np = (ct_poll == 0 || ct_poll > 4) ? 4 : ct_poll;
    for (int i = 0; i < np; i++) exp_q.push_back('{1'b0, 64'h58, 32'h0});
    if (ct_poll == 0 || ct_poll > 4) begin exp_q.push_back('{1'b1, 64'h0, 32'h0}); return; end
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 64'(96 + 8 * k), 32'h0});
    exp_q.push_back('{1'b1, 64'h0, 32'h0});
    ect = ct_val;
    eer = 1'b0;
  endtask
  task automatic do_cmd(input logic [1:0] ks, input logic [191:0] key, input logic [127:0] st, pt,
                        input bit hold, input int dly, output logic [127:0] ct, output logic er,
                        output logic [127:0] ect, output logic eer, output logic held);
    int n;
    wr_n = 0;
    poll_n = 0;
    push_exp(ks, key, st, pt, ect, eer);
    @(negedge clk_i);
    cmd_valid_i = 1;
    cmd_ksel_i = ks;
    cmd_key_i = key;
    cmd_state_i = st;
    cmd_pt_i = pt;
    n = 0;
    while (!cmd_ready_o && n < 100) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    if (!hold) cmd_valid_i = 0;
    n = 0;
    while (!res_valid_o && n < 5000) begin @(negedge clk_i); n++; end
    if (!res_valid_o) begin
      errors++;
      checks++;
      $display("FAIL res_wait: res_valid still 0 after %0d cycles, required 1", n);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
    cmd_valid_i = 0;
    repeat (dly) @(negedge clk_i);
    held = res_valid_o;
    ct = res_ct_o;
    er = res_err_o;
    res_ready_i = 1;
    @(negedge clk_i);
    res_ready_i = 0;
  endtask
  task automatic test_reset;
    rst_1 = 1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, res_valid_o, busy_o} !== 7'h0) begin
      errors++;
      $display("FAIL rst_valids: got %b, required 0000000", {aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, res_valid_o, busy_o});
    end
    checks++;
    if (res_ct_o !== 128'h0 || res_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_res: got ct=%h err=%b, required 0/0", res_ct_o, res_err_o);
    end
    checks++;
    if (aw_addr_o !== 64'h0 || ar_addr_o !== 64'h0 || w_data_o !== 64'h0 || w_strb_o !== 8'h0) begin
      errors++;
      $display("FAIL rst_bus: got aw=%h ar=%h wd=%h ws=%h, required all 0", aw_addr_o, ar_addr_o, w_data_o, w_strb_o);
    end
    rst_1 = 0;
    res_ready_i = 1;
    repeat (4) @(negedge clk_i);
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_res_ready: got res_valid=%b busy=%b cmd_ready=%b, required 0/0/1", res_valid_o, busy_o, cmd_ready_o);
    end
    res_ready_i = 0;
  endtask
  task automatic test_scenario(input string name, input logic [1:0] ks, input int stl, input int cp, input int be,
                               input bit hold);
    logic [127:0] ct, ect;
    logic er, eer, held;
    stall = stl;
    ct_poll = cp;
    berr_n = be;
    viol = 0;
    exp_q.delete();
    act_q.delete();
    do_cmd(ks, KEY, ST, PT, hold, 3, ct, er, ect, eer, held);
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL %s_held: res_valid=%b before res_ready, required 1", name, held); end
    checks++;
    if (ct !== ect) begin errors++; $display("FAIL %s_ct: got %h, required %h", name, ct, ect); end
    checks++;
    if (er !== eer) begin errors++; $display("FAIL %s_err: got %b, required %b", name, er, eer); end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d accesses, required %0d", name, act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a.wr !== e.wr || a.addr !== e.addr || a.data !== e.data) begin
        errors++;
        $display("FAIL %s_acc: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                 name, a.wr, a.addr, a.data, e.wr, e.addr, e.data);
      end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL %s_protocol: got %0d violations, required 0", name, viol); end
    repeat (5) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || act_q.size() != 0) begin
      errors++;
      $display("FAIL %s_quiet: got busy=%b extra=%0d, required 0/0", name, busy_o, act_q.size());
    end
  endtask
  task automatic test_basic;
    test_scenario("basic", 2'd1, 0, 3, 0, 0);
  endtask
  task automatic test_stalls;
    test_scenario("stall", 2'd1, 5, 3, 0, 0);
  endtask
  task automatic test_ksel;
    test_scenario("ksel0", 2'd0, 0, 1, 0, 0);
    test_scenario("ksel3", 2'd3, 2, 2, 0, 0);
  endtask
  task automatic test_timeout;
    test_scenario("timeout", 2'd2, 1, 0, 0, 0);
  endtask
  task automatic test_bus_error;
    test_scenario("berr", 2'd1, 0, 3, 3, 0);
  endtask
  task automatic test_busy_ignore;
    test_scenario("busy", 2'd1, 1, 2, 0, 1);
  endtask
  task automatic test_reset_mid;
    int n;
    stall = 0;
    ct_poll = 3;
    berr_n = 0;
    wr_n = 0;
    poll_n = 0;
    @(negedge clk_i);
    cmd_valid_i = 1;
    cmd_ksel_i = 2'd1;
    cmd_key_i = KEY;
    @(negedge clk_i);
    cmd_valid_i = 0;
    n = 0;
    while (!r_ready_o && n < 500) begin @(negedge clk_i); n++; end
    checks++;
    if (r_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rdata: r_ready=%b, required 1", r_ready_o); end
    rst_1 = 1;
    @(posedge clk_i);
    #1;
    checks++;
    if ({aw_valid_o, w_valid_o, ar_valid_o, res_valid_o, busy_o, cmd_ready_o} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_reset: got aw/w/ar/res/busy/cmd_ready=%b, required 000001",
               {aw_valid_o, w_valid_o, ar_valid_o, res_valid_o, busy_o, cmd_ready_o});
    end
    @(negedge clk_i);
    rst_1 = 0;
    test_scenario("after_rst", 2'd1, 0, 3, 0, 0);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_ksel();
    test_timeout();
    test_bus_error();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
